multi_shape_processor: RTL and testbench



---
 rtl/multi_shape_processor.sv | 169 ++++++++++++++++
 tb/tb_multi_shape_processor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_shape_processor.sv
// multi_shape_processor
// NUM_CHANNELS independent control SFRs (shape + operation) behind a single
// addressed read/write port. Each channel has a busy window after every
// accepted write. Reads and error pulses are registered.
// Optional feature macro: SHAPE_PROC_ERR_CNT_EN adds an 8-bit saturating
// reject counter, returned in read_data[31:24] and cleared by every valid read.
module multi_shape_processor #(
  parameter int  NUM_CHANNELS = 4,
  parameter int  BUSY_CYCLES  = 3,
  localparam int ADDR_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [31:0]             write_data,
  input  logic                    read,
  output logic [31:0]             read_data,
  output logic                    read_valid,
  output logic                    error,
  output logic [NUM_CHANNELS-1:0] busy
);

  localparam logic [ADDR_W:0] NUM_CH_W  = NUM_CHANNELS[ADDR_W:0];
  localparam logic [7:0]      BUSY_LOAD = BUSY_CYCLES[7:0];

  logic [1:0]  shape_q [NUM_CHANNELS];
  logic [1:0]  shape_d [NUM_CHANNELS];
  logic [5:0]  op_q    [NUM_CHANNELS];
  logic [5:0]  op_d    [NUM_CHANNELS];
  logic [7:0]  cnt_q   [NUM_CHANNELS];
  logic [7:0]  cnt_d   [NUM_CHANNELS];

  logic [31:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        error_q, error_d;

`ifdef SHAPE_PROC_ERR_CNT_EN
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  err_base;
  logic [8:0]  err_sum;
`endif

  logic        addr_ok;
  logic [1:0]  cur_shape, new_shape;
  logic [5:0]  cur_op, new_op;
  logic        cur_busy;
  logic        combo_legal;
  logic        wr_accept, wr_reject, rd_bad;

  // Only [17:16] and [5:0] of write_data carry fields.
  logic        unused_wdata_bits;
  assign unused_wdata_bits = ^{write_data[31:18], write_data[15:6]};

  function automatic logic shape_legal(input logic [1:0] s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  function automatic logic op_legal(input logic [5:0] o);
    logic ok;
    case (o[5:4])
      2'b00:   ok = (o[3:0] <= 4'd1);
      2'b01:   ok = (o[3:0] == 4'd0);
      2'b10:   ok = (o[3:0] <= 4'd1);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Decode the addressed channel, resolve the keep rule and judge the request
  always_comb begin
    addr_ok   = ({1'b0, addr} < NUM_CH_W);
    cur_shape = 2'b01;
    cur_op    = 6'd0;
    cur_busy  = 1'b0;
    if (addr_ok) begin
      cur_shape = shape_q[addr];
      cur_op    = op_q[addr];
      cur_busy  = (cnt_q[addr] != 8'd0);
    end
    new_shape   = (write_data[17:16] == 2'b11)  ? cur_shape : write_data[17:16];
    new_op      = (write_data[5:0]   == 6'h3F)  ? cur_op    : write_data[5:0];
    combo_legal = shape_legal(new_shape) && op_legal(new_op) &&
                  ((new_op[5:4] == 2'b00) || (new_op[5:4] == new_shape));
    wr_accept   = write && addr_ok && !cur_busy && combo_legal;
    wr_reject   = write && !wr_accept;
    rd_bad      = read && !addr_ok;
  end

  // Per-channel SFR update and busy countdown
  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      shape_d[ch] = shape_q[ch];
      op_d[ch]    = op_q[ch];
      cnt_d[ch]   = (cnt_q[ch] != 8'd0) ? cnt_q[ch] - 8'd1 : 8'd0;
      if (wr_accept && (addr == ADDR_W'(ch))) begin
        shape_d[ch] = new_shape;
        op_d[ch]    = new_op;
        cnt_d[ch]   = BUSY_LOAD;
      end
    end
  end

  // Registered read result and error pulse; read sees pre-write state
  always_comb begin
    read_valid_d = read;
    error_d      = wr_reject || rd_bad;
    read_data_d  = read_data_q;
    if (read) begin
      read_data_d = 32'd0;
      if (addr_ok) begin
        read_data_d[17:16] = cur_shape;
        read_data_d[8]     = cur_busy;
        read_data_d[5:0]   = cur_op;
`ifdef SHAPE_PROC_ERR_CNT_EN
        read_data_d[31:24] = err_cnt_q;
`endif
      end
    end
  end

`ifdef SHAPE_PROC_ERR_CNT_EN
  // Reject counter: a valid read clears it before this cycle's rejects are added
  always_comb begin
    err_base  = (read && addr_ok) ? 8'd0 : err_cnt_q;
    err_sum   = {1'b0, err_base} + {8'd0, wr_reject} + {8'd0, rd_bad};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end
`endif

  // Busy flags follow the countdown directly
  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      busy[ch] = (cnt_q[ch] != 8'd0);
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign error      = error_q;

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        shape_q[ch] <= 2'b01;
        op_q[ch]    <= 6'd0;
        cnt_q[ch]   <= 8'd0;
      end
      read_data_q  <= 32'd0;
      read_valid_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef SHAPE_PROC_ERR_CNT_EN
      err_cnt_q    <= 8'd0;
`endif
    end else begin
      shape_q      <= shape_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      error_q      <= error_d;
`ifdef SHAPE_PROC_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_multi_shape_processor.sv
// Bench for multi_shape_processor: directed steps followed by random traffic,
// all checked against a cycle-indexed reference model of the channel SFRs.
module tb_multi_shape_processor;

  localparam int NC = 3;
  localparam int BC = 3;
  localparam int AW = 2;
`ifdef SHAPE_PROC_ERR_CNT_EN
  localparam bit ERRC = 1'b1;
`else
  localparam bit ERRC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   write_data = 32'd0;
  logic [31:0]   read_data;
  logic          read_valid;
  logic          error;
  logic [NC-1:0] busy;

  int errors = 0;
  int checks = 0;

  // Reference model: channel fields, the edge index until which each channel
  // is busy, the index of the last completed edge, held read data, reject count.
  int          m_shape [NC];
  int          m_op    [NC];
  int          m_until [NC];
  int          m_cyc;
  int          m_err;
  logic [31:0] m_rd;

  multi_shape_processor #(.NUM_CHANNELS(NC), .BUSY_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .addr       (addr),
    .write_data (write_data),
    .read       (read),
    .read_data  (read_data),
    .read_valid (read_valid),
    .error      (error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit legal(input int s, input int o);
    int  cls  = o / 16;
    int  low  = o % 16;
    bit  ok_s = (s == 1) || (s == 2);
    bit  ok_o = (cls == 0 && low <= 1) || (cls == 1 && low == 0) || (cls == 2 && low <= 1);
    return ok_s && ok_o && (cls == 0 || cls == s);
  endfunction

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NC; ch++) begin
      m_shape[ch] = 1;
      m_op[ch]    = 0;
      m_until[ch] = 0;
    end
    m_cyc = 0;
    m_err = 0;
    m_rd  = 32'd0;
  endtask

  // One clock of traffic: drive at negedge, predict from pre-edge model state,
  // check all outputs 1 time unit after the rising edge.
  task automatic step(input string tag, input bit w, input int a,
                      input logic [31:0] wd, input bit r);
    int          s, o;
    bit          acc, wrej, rbad, rok, bsy;
    logic [31:0] e_rd, e_busy;
    @(negedge clk);
    write      = w;
    addr       = AW'(a);
    write_data = wd;
    read       = r;
    rok  = r && (a < NC);
    rbad = r && (a >= NC);
    e_rd = m_rd;
    if (rok) begin
      bsy  = (m_cyc < m_until[a]);
      e_rd = (ERRC ? (32'(m_err) << 24) : 32'd0) | (32'(m_shape[a]) << 16) |
             (32'(bsy) << 8) | 32'(m_op[a]);
    end else if (rbad) begin
      e_rd = 32'd0;
    end
    acc  = 1'b0;
    wrej = 1'b0;
    s    = 0;
    o    = 0;
    if (w) begin
      if (a < NC) begin
        s   = (wd[17:16] == 2'b11) ? m_shape[a] : int'(wd[17:16]);
        o   = (wd[5:0] == 6'h3F)   ? m_op[a]    : int'(wd[5:0]);
        acc = !(m_cyc < m_until[a]) && legal(s, o);
      end
      wrej = !acc;
    end
    if (rok) m_err = 0;
    m_err = m_err + int'(wrej) + int'(rbad);
    if (m_err > 255) m_err = 255;
    m_rd = e_rd;
    if (acc) begin
      m_shape[a] = s;
      m_op[a]    = o;
      m_until[a] = m_cyc + 1 + BC;
    end
    @(posedge clk);
    m_cyc++;
    #1;
    e_busy = 32'd0;
    for (int ch = 0; ch < NC; ch++) if (m_cyc < m_until[ch]) e_busy[ch] = 1'b1;
    chk32({tag, ".read_data"},  read_data,         e_rd);
    chk32({tag, ".read_valid"}, 32'(read_valid),   32'(r));
    chk32({tag, ".error"},      32'(error),        32'(wrej || rbad));
    chk32({tag, ".busy"},       32'(busy),         e_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [31:0] wd;
    int          pick;

    // Reset values
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk32("rst.read_data",  read_data,       32'd0);
    chk32("rst.read_valid", 32'(read_valid), 32'd0);
    chk32("rst.error",      32'(error),      32'd0);
    chk32("rst.busy",       32'(busy),       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Read every address after reset; address 3 is out of range here
    for (int a = 0; a < 4; a++) begin
      step("rst_read", 1'b0, a, 32'd0, 1'b1);
      if (a < NC) chk32("rst_read.const", read_data & 32'h00FF_FFFF, 32'h0001_0000);
    end

    // Legal write to ch2, observe busy window through reads
    step("wr_ch2", 1'b1, 2, 32'h0002_0021, 1'b0);
    chk32("wr_ch2.noerr", 32'(error), 32'd0);
    step("rd_ch2_win", 1'b0, 2, 32'd0, 1'b1);
    chk32("rd_ch2_win.const", read_data & 32'h00FF_FFFF, 32'h0002_0121);
    step("rd_ch2_win", 1'b0, 2, 32'd0, 1'b1);
    step("rd_ch2_win", 1'b0, 2, 32'd0, 1'b1);
    step("rd_ch2_after", 1'b0, 2, 32'd0, 1'b1);
    chk32("rd_ch2_after.const", read_data & 32'h00FF_FFFF, 32'h0002_0021);

    // Illegal combination on ch1, then a both-keep write
    step("wr_ch1_bad", 1'b1, 1, 32'h0001_0021, 1'b0);
    chk32("wr_ch1_bad.err", 32'(error), 32'd1);
    step("rd_ch1", 1'b0, 1, 32'd0, 1'b1);
    chk32("rd_ch1.const", read_data & 32'h00FF_FFFF, 32'h0001_0000);
    step("wr_ch1_keep", 1'b1, 1, 32'h0003_003F, 1'b0);
    chk32("wr_ch1_keep.noerr", 32'(error), 32'd0);
    idle(3);
    step("rd_ch1_keep", 1'b0, 1, 32'd0, 1'b1);

    // Back-to-back writes to ch0, retry when busy has dropped
    step("wr_ch0_a", 1'b1, 0, 32'h0001_0000, 1'b0);
    step("wr_ch0_busy", 1'b1, 0, 32'h0001_0010, 1'b0);
    chk32("wr_ch0_busy.err", 32'(error), 32'd1);
    step("wr_ch0_last_busy", 1'b0, 0, 32'd0, 1'b0);
    step("wr_ch0_last_busy", 1'b1, 0, 32'h0001_0010, 1'b0);
    step("wr_ch0_retry", 1'b1, 0, 32'h0001_0010, 1'b0);
    chk32("wr_ch0_retry.noerr", 32'(error), 32'd0);
    idle(3);

    // Same-cycle read and write of ch0 returns the old value
    step("rdwr_ch0", 1'b1, 0, 32'h0002_0021, 1'b1);
    chk32("rdwr_ch0.old", read_data & 32'h00FF_FFFF, 32'h0001_0010);
    step("rd_ch0_new", 1'b0, 0, 32'd0, 1'b1);

    // Invalid address read, alone and together with a write
    step("rd_bad", 1'b0, 3, 32'd0, 1'b1);
    chk32("rd_bad.data", read_data, 32'd0);
    step("rdwr_bad", 1'b1, 3, 32'h0001_0000, 1'b1);

    // Many rejects: the counter saturates, a valid read returns and clears it
    for (int i = 0; i < 300; i++) step("rej", 1'b1, 1, 32'h0001_0021, 1'b0);
    step("rd_sat", 1'b0, 2, 32'd0, 1'b1);
    chk32("rd_sat.cnt", 32'(read_data[31:24]), ERRC ? 32'd255 : 32'd0);
    step("rd_clr", 1'b0, 2, 32'd0, 1'b1);
    chk32("rd_clr.cnt", 32'(read_data[31:24]), 32'd0);
    step("rej_rd", 1'b1, 1, 32'h0001_0021, 1'b1);
    step("rd_one", 1'b0, 0, 32'd0, 1'b1);
    chk32("rd_one.cnt", 32'(read_data[31:24]), ERRC ? 32'd1 : 32'd0);

    // Reset in the middle of a busy window with a read in flight
    step("wr_pre_rst", 1'b1, 1, 32'h0002_0020, 1'b0);
    @(negedge clk);
    read  = 1'b1;
    addr  = AW'(1);
    write = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk32("midrst.read_valid", 32'(read_valid), 32'd0);
    chk32("midrst.busy",       32'(busy),       32'd0);
    chk32("midrst.read_data",  read_data,       32'd0);
    chk32("midrst.error",      32'(error),      32'd0);
    @(negedge clk);
    read = 1'b0;
    rst  = 1'b0;
    step("rd_post_rst", 1'b0, 1, 32'd0, 1'b1);
    chk32("rd_post_rst.const", read_data & 32'h00FF_FFFF, 32'h0001_0000);

    // Random traffic biased toward legal field values
    for (int i = 0; i < 1500; i++) begin
      wd   = $urandom;
      pick = $urandom_range(0, 7);
      case (pick)
        0: wd[5:0] = 6'h00;
        1: wd[5:0] = 6'h01;
        2: wd[5:0] = 6'h10;
        3: wd[5:0] = 6'h20;
        4: wd[5:0] = 6'h21;
        5: wd[5:0] = 6'h3F;
        default: ;
      endcase
      step("rnd", bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), wd,
           bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
